// File: rtl/capp_controller.sv
// Command-side controller for the CAPP cell array: drives dual-rail search/write lines,
// owns the tag (responder) register and resolves multiple responders to the lowest index.
module capp_controller #(
   parameter int WORDS  = 100,
   parameter int WIDTH  = 32,
   parameter int SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_data,
   input  logic [WIDTH-1:0]             cmd_mask,
   output logic                         rsp_valid,
   output logic                         rsp_hit,
   output logic [$clog2(WORDS)-1:0]     rsp_index,
   output logic [$clog2(WORDS+1)-1:0]   rsp_count,
   output logic [WIDTH-1:0]             rsp_data,
   output logic [2*WIDTH-1:0]           mismatch_lines,
   output logic [2*WIDTH-1:0]           write_lines,
   output logic [WORDS-1:0]             word_sel,
   input  logic [WORDS-1:0]             match_lines,
   input  logic [WIDTH-1:0]             read_lines
);

   localparam int IW = $clog2(WORDS);
   localparam int CW = $clog2(WORDS+1);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] LAST = SW'(SETTLE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESP} state_e;
   typedef enum logic [1:0] {OP_SEARCH = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_NEXT = 2'b11} op_e;

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [SW-1:0]        cnt_q, cnt_d;
   logic [WORDS-1:0]     tag_q, tag_d;
   logic [2*WIDTH-1:0]   mism_q, mism_d, wr_q, wr_d;
   logic [WORDS-1:0]     sel_q, sel_d;
   logic                 rsp_load;
   logic                 rsp_hit_q, rsp_hit_d;
   logic [IW-1:0]        rsp_index_q, rsp_index_d;
   logic [CW-1:0]        rsp_count_q, rsp_count_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;

   // Interleave two per-bit rails: even line carries on1, odd line carries on0.
   function automatic logic [2*WIDTH-1:0] rails(input logic [WIDTH-1:0] on1, input logic [WIDTH-1:0] on0);
      logic [2*WIDTH-1:0] r;
      for (int j = 0; j < WIDTH; j++) begin
         r[2*j]   = on1[j];
         r[2*j+1] = on0[j];
      end
      return r;
   endfunction

   function automatic logic [IW-1:0] lowest_idx(input logic [WORDS-1:0] v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = WORDS - 1; i >= 0; i--)
         if (v[i]) idx = IW'(i);
      return idx;
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [WORDS-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WORDS; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      tag_d      = tag_q;
      mism_d     = '0;
      wr_d       = '0;
      sel_d      = '0;
      rsp_load   = 1'b0;
      rsp_data_d = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               cnt_d   = '0;
               state_d = ST_DRIVE;
               case (op_e'(cmd_op))
                  OP_SEARCH: mism_d = rails(cmd_mask & ~cmd_data, cmd_mask & cmd_data);
                  OP_WRITE: begin
                     wr_d  = rails(cmd_mask & cmd_data, cmd_mask & ~cmd_data);
                     sel_d = tag_q;
                  end
                  OP_READ:  sel_d = tag_q & (~tag_q + WORDS'(1));
                  default: begin
                     tag_d      = tag_q & (tag_q - WORDS'(1));
                     rsp_load   = 1'b1;
                     rsp_data_d = '0;
                     state_d    = ST_RESP;
                  end
               endcase
            end
         end
         ST_DRIVE: begin
            if (cnt_q == LAST) begin
               state_d    = ST_RESP;
               rsp_load   = 1'b1;
               rsp_data_d = '0;
               if (op_q == OP_SEARCH) tag_d = ~match_lines;
               if (op_q == OP_READ && |tag_q) rsp_data_d = read_lines;
            end else begin
               cnt_d  = cnt_q + SW'(1);
               mism_d = mism_q;
               wr_d   = wr_q;
               sel_d  = sel_q;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Response fields reflect the tag as it will be after this command completes.
      rsp_hit_d   = rsp_hit_q;
      rsp_index_d = rsp_index_q;
      rsp_count_d = rsp_count_q;
      if (rsp_load) begin
         rsp_hit_d   = |tag_d;
         rsp_index_d = lowest_idx(tag_d);
         rsp_count_d = popcount(tag_d);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_SEARCH;
         cnt_q       <= '0;
         tag_q       <= '0;
         mism_q      <= '0;
         wr_q        <= '0;
         sel_q       <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_index_q <= '0;
         rsp_count_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         mism_q      <= mism_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_index_q <= rsp_index_d;
         rsp_count_q <= rsp_count_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign cmd_ready      = (state_q == ST_IDLE);
   assign rsp_valid      = (state_q == ST_RESP);
   assign rsp_hit        = rsp_hit_q;
   assign rsp_index      = rsp_index_q;
   assign rsp_count      = rsp_count_q;
   assign rsp_data       = rsp_data_q;
   assign mismatch_lines = mism_q;
   assign write_lines    = wr_q;
   assign word_sel       = sel_q;

endmodule

// File: tb/tb_capp_controller.sv
// Bench for capp_controller: behavioural cell-array model plus a word-level reference
// model of tag/memory state, driven by directed and randomized commands.
module tb_capp_controller;

   localparam int WORDS  = 100;
   localparam int WIDTH  = 32;
   localparam int SETTLE = 3;
   localparam int IW     = $clog2(WORDS);
   localparam int CW     = $clog2(WORDS+1);

   localparam logic [1:0] SEARCH = 2'b00, WRITE = 2'b01, READ = 2'b10, NEXT = 2'b11;

   typedef struct {
      logic               hit;
      logic [IW-1:0]      idx;
      logic [CW-1:0]      cnt;
      logic [WIDTH-1:0]   data;
      logic [2*WIDTH-1:0] mism;
      logic [2*WIDTH-1:0] wr;
      logic [WORDS-1:0]   sel;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cmd_valid, cmd_ready;
   logic [1:0]           cmd_op;
   logic [WIDTH-1:0]     cmd_data, cmd_mask;
   logic                 rsp_valid, rsp_hit;
   logic [IW-1:0]        rsp_index;
   logic [CW-1:0]        rsp_count;
   logic [WIDTH-1:0]     rsp_data;
   logic [2*WIDTH-1:0]   mismatch_lines, write_lines;
   logic [WORDS-1:0]     word_sel, match_lines;
   logic [WIDTH-1:0]     read_lines;

   logic [WIDTH-1:0]     arr_mem [WORDS];
   logic [WIDTH-1:0]     ref_mem [WORDS];
   logic [WORDS-1:0]     ref_tag;
   logic                 load_env;
   int                   compared = 0;
   int                   mismatched = 0;

   capp_controller #(.WORDS(WORDS), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
      .rsp_count(rsp_count), .rsp_data(rsp_data),
      .mismatch_lines(mismatch_lines), .write_lines(write_lines), .word_sel(word_sel),
      .match_lines(match_lines), .read_lines(read_lines)
   );

   always #5 clk = ~clk;

   // Cell array: a word mismatches when any driven rail disagrees with its stored bit.
   always_comb begin
      match_lines = '0;
      read_lines  = '0;
      for (int w = 0; w < WORDS; w++) begin
         for (int j = 0; j < WIDTH; j++)
            if ((arr_mem[w][j] && mismatch_lines[2*j]) || (!arr_mem[w][j] && mismatch_lines[2*j+1]))
               match_lines[w] = 1'b1;
         if (word_sel[w]) read_lines = read_lines | arr_mem[w];
      end
   end

   always @(posedge clk) begin
      for (int w = 0; w < WORDS; w++) begin
         if (load_env) arr_mem[w] <= ref_mem[w];
         else if (word_sel[w])
            for (int j = 0; j < WIDTH; j++) begin
               if (write_lines[2*j]) arr_mem[w][j] <= 1'b1;
               else if (write_lines[2*j+1]) arr_mem[w][j] <= 1'b0;
            end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [WORDS-1:0] t);
      for (int i = 0; i < WORDS; i++) if (t[i]) return i;
      return -1;
   endfunction

   // Reference model: word-level semantics of each command on tag and memory.
   task automatic model(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m,
                        output exp_t e);
      int lo;
      e.mism = '0; e.wr = '0; e.sel = '0; e.data = '0;
      case (op)
         SEARCH: begin
            for (int j = 0; j < WIDTH; j++) begin
               e.mism[2*j]   = m[j] & ~d[j];
               e.mism[2*j+1] = m[j] & d[j];
            end
            for (int w = 0; w < WORDS; w++) ref_tag[w] = (((ref_mem[w] ^ d) & m) == '0);
         end
         WRITE: begin
            e.sel = ref_tag;
            for (int j = 0; j < WIDTH; j++) begin
               e.wr[2*j]   = m[j] & d[j];
               e.wr[2*j+1] = m[j] & ~d[j];
            end
            for (int w = 0; w < WORDS; w++)
               if (ref_tag[w]) ref_mem[w] = (ref_mem[w] & ~m) | (d & m);
         end
         READ: begin
            lo = lowest(ref_tag);
            if (lo >= 0) begin
               e.sel[lo] = 1'b1;
               e.data    = ref_mem[lo];
            end
         end
         default: begin
            lo = lowest(ref_tag);
            if (lo >= 0) ref_tag[lo] = 1'b0;
         end
      endcase
      lo    = lowest(ref_tag);
      e.hit = (lo >= 0);
      e.idx = (lo >= 0) ? IW'(lo) : '0;
      e.cnt = CW'($countones(ref_tag));
   endtask

   task automatic check_rsp(input string name, input exp_t e);
      check({name, ".hit"},   rsp_hit,   e.hit);
      check({name, ".index"}, rsp_index, e.idx);
      check({name, ".count"}, rsp_count, e.cnt);
      check({name, ".data"},  rsp_data,  e.data);
   endtask

   task automatic run_cmd(input string name, input logic [1:0] op, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] m);
      exp_t e;
      int   lat;
      model(op, d, m, e);
      @(negedge clk);
      check({name, ".ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
      lat = 1;
      while (!rsp_valid && lat <= SETTLE + 4) begin
         check({name, ".mism"}, mismatch_lines, e.mism);
         check({name, ".wr"},   write_lines,    e.wr);
         check({name, ".sel"},  word_sel,       e.sel);
         @(negedge clk);
         lat++;
      end
      check({name, ".latency"}, lat, (op == NEXT) ? 1 : SETTLE + 1);
      check_rsp(name, e);
      check({name, ".idle_lines"}, {mismatch_lines, write_lines}, '0);
      check({name, ".idle_sel"}, word_sel, '0);
      @(negedge clk);
      check({name, ".strobe"}, {rsp_valid, cmd_ready}, 2'b01);
      check({name, ".hold"}, {rsp_hit, rsp_count, rsp_data}, {e.hit, e.cnt, e.data});
   endtask

   task automatic rand_cmd(output logic [1:0] op, output logic [WIDTH-1:0] d, output logic [WIDTH-1:0] m);
      op = 2'($urandom_range(0, 3));
      d  = $urandom_range(0, 1) ? ref_mem[$urandom_range(0, WORDS-1)] : $urandom;
      case ($urandom_range(0, 3))
         0:       m = '0;
         1:       m = '1;
         default: m = $urandom;
      endcase
   endtask

   initial begin
      exp_t       e, x;
      exp_t       q[$];
      logic [1:0] op;
      logic [WIDTH-1:0] d, m;
      int issued, got, cyc;
      logic seen;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0; load_env = 1'b1;
      ref_tag = '0;
      for (int w = 0; w < WORDS; w++) ref_mem[w] = $urandom | 32'h8000_0000;
      ref_mem[0] = 32'h456;
      ref_mem[1] = 32'h457;
      repeat (2) @(negedge clk);
      load_env = 1'b0;

      check("rst.ready", cmd_ready, 1'b1);
      check("rst.valid", rsp_valid, 1'b0);
      check("rst.lines", {mismatch_lines, write_lines}, '0);
      check("rst.sel", word_sel, '0);
      check("rst.rsp", {rsp_hit, rsp_index, rsp_count, rsp_data}, '0);
      rst_n = 1'b1;

      // Empty mask tags every word.
      run_cmd("all", SEARCH, $urandom, '0);

      // Asynchronous reset while a WRITE is driving: everything drops, no response.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = WRITE; cmd_data = $urandom; cmd_mask = '0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("abort.sel_before", word_sel, ref_tag);
      #2 rst_n = 1'b0;
      #1;
      check("abort.sel", word_sel, '0);
      check("abort.lines", {mismatch_lines, write_lines}, '0);
      check("abort.ready", cmd_ready, 1'b1);
      ref_tag = '0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("abort.no_rsp", seen, 1'b0);
      run_cmd("abort.next", NEXT, '0, '0);

      run_cmd("s_exact", SEARCH, 32'h456, 32'hFFFF_FFFF);
      run_cmd("s_lsb",   SEARCH, 32'h456, 32'hFFFF_FFFE);
      run_cmd("rd0",     READ,   $urandom, $urandom);
      run_cmd("nx0",     NEXT,   $urandom, $urandom);
      run_cmd("rd1",     READ,   $urandom, $urandom);
      run_cmd("nx1",     NEXT,   $urandom, $urandom);
      run_cmd("rd_empty", READ,  $urandom, $urandom);
      run_cmd("nx_empty", NEXT,  $urandom, $urandom);

      run_cmd("s_retag", SEARCH, 32'h456, 32'hFFFF_FFFE);
      run_cmd("wr",      WRITE,  32'h0000_FFFF, 32'h0000_00FF);
      run_cmd("rd_wr0",  READ,   '0, '0);
      run_cmd("nx_wr",   NEXT,   '0, '0);
      run_cmd("rd_wr1",  READ,   '0, '0);
      run_cmd("s_none",  SEARCH, 32'h456, 32'hFFFF_FFFF);

      for (int i = 0; i < 40; i++) begin
         rand_cmd(op, d, m);
         run_cmd($sformatf("rnd%0d", i), op, d, m);
      end

      // Back-to-back: cmd_valid stays high, one accept per response.
      issued = 0; got = 0; cyc = 0;
      @(negedge clk);
      while ((issued < 30 || got < issued) && cyc < 2000) begin
         if (rsp_valid) begin
            if (q.size() == 0) check("b2b.dup_rsp", 1'b1, 1'b0);
            else begin
               x = q.pop_front();
               check_rsp($sformatf("b2b%0d", got), x);
            end
            got++;
         end
         if (cmd_ready) begin
            if (issued < 30) begin
               rand_cmd(op, d, m);
               model(op, d, m, e);
               q.push_back(e);
               cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
               issued++;
            end else cmd_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      cmd_valid = 1'b0;
      check("b2b.responses", got, 30);
      check("b2b.pending", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
